// File: rtl/bits_please_pkg.sv
// Shared definitions for the BitsPlease pushbutton front end: FSM state
// encoding, board-clock timing defaults and a constant-width helper.
package bits_please_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_e;

  // Timing defaults for the 50 MHz board clock: 5 ms debounce,
  // 500 ms before the first auto-repeat, then one repeat every 100 ms.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 5000000;

  // Ceiling log2, usable in constant expressions for sizing vectors.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Largest of three values, used to size the shared per-button counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/button_fsm.sv
// One pushbutton: two-flop synchroniser, debounce/auto-repeat FSM and its
// saturating counter. Produces a one-cycle press pulse and the debounced level.
module button_fsm
  import bits_please_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw_i,
  input  logic repeat_en_i,
  output logic pulse_o,
  output logic held_o
);

  // One counter serves debounce, repeat delay and repeat period, so it is
  // sized for the largest of the three and saturates instead of wrapping.
  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned CNT_W   = (clog2(CNT_MAX + 1) < 1) ? 1 : clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_LIMIT = CNT_W'(REPEAT_PERIOD);

  logic             meta_q;
  logic             sync_q;
  logic             pressed;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             pulse_q;
  logic             held_q;

  // Two-stage synchroniser; reset parks both flops at the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= ACTIVE_LOW;
      sync_q <= ACTIVE_LOW;
    end else begin
      meta_q <= button_raw_i;
      sync_q <= meta_q;
    end
  end

  assign pressed = sync_q ^ ACTIVE_LOW;
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  // Debounce/repeat FSM with registered pulse and held outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed) begin
            if (DEBOUNCE_CYCLES <= 1) begin
              state_q <= PRESSED;
              held_q  <= 1'b1;
              pulse_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= DB_PRESS;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        DB_PRESS: begin
          if (!pressed) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_inc >= DB_LIMIT) begin
            state_q <= PRESSED;
            held_q  <= 1'b1;
            pulse_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        PRESSED, REPEAT: begin
          if (!pressed) begin
            if (DEBOUNCE_CYCLES <= 1) begin
              state_q <= IDLE;
              held_q  <= 1'b0;
              cnt_q   <= '0;
            end else begin
              state_q <= DB_RELEASE;
              cnt_q   <= CNT_W'(1);
            end
          end else if (repeat_en_i) begin
            if (cnt_inc >= ((state_q == PRESSED) ? RD_LIMIT : RP_LIMIT)) begin
              state_q <= REPEAT;
              pulse_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        DB_RELEASE: begin
          if (pressed) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_inc >= DB_LIMIT) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pulse_o = pulse_q;
  assign held_o  = held_q;

endmodule

// File: rtl/button_router.sv
// N debounced pushbuttons routed to one of M consumer channels, with a
// lock-out so a button held across a select change never leaks pulses
// into the newly selected consumer.
module button_router
  import bits_please_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 3,
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned SEL_W           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_BUTTONS-1:0]              buttons_raw,
  input  logic [SEL_W-1:0]                    channel_select,
  input  logic [NUM_BUTTONS-1:0]              repeat_en,
  output logic [NUM_CHANNELS*NUM_BUTTONS-1:0] pulses_out,
  output logic [NUM_BUTTONS-1:0]              held,
  output logic                                locked
);

  logic [NUM_BUTTONS-1:0]              raw_pulse;
  logic [SEL_W-1:0]                    sel_q;
  logic [SEL_W-1:0]                    sel_d;
  logic                                locked_q;
  logic                                locked_d;
  logic [NUM_CHANNELS*NUM_BUTTONS-1:0] pulses_q;
  logic [NUM_CHANNELS*NUM_BUTTONS-1:0] pulses_d;

  for (genvar gb = 0; gb < NUM_BUTTONS; gb++) begin : g_button
    button_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .button_raw_i(buttons_raw[gb]),
      .repeat_en_i (repeat_en[gb]),
      .pulse_o     (raw_pulse[gb]),
      .held_o      (held[gb])
    );
  end

  // Next select, lock state and routed pulses; a pulse follows the new
  // select unless this same edge is setting the lock.
  always_comb begin
    sel_d    = channel_select;
    locked_d = locked_q;
    pulses_d = '0;
    if ((sel_d != sel_q) && (|held)) begin
      locked_d = 1'b1;
    end else if (!(|held)) begin
      locked_d = 1'b0;
    end
    if (!locked_d) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (sel_d == SEL_W'(c)) begin
          pulses_d[c*NUM_BUTTONS +: NUM_BUTTONS] = raw_pulse;
        end
      end
    end
  end

  // Register select, lock and the routed pulse vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q    <= '0;
      locked_q <= 1'b0;
      pulses_q <= '0;
    end else begin
      sel_q    <= sel_d;
      locked_q <= locked_d;
      pulses_q <= pulses_d;
    end
  end

  assign pulses_out = pulses_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_button_router.sv
// Bench for button_router: two instances (4 channels and 3 channels) share
// one stimulus stream; a run-length model of debounce, repeat and routing
// predicts every cycle, plus directed checks on latencies and pulse counts.
`timescale 1ns/1ps
module tb_button_router;

  localparam int NB = 3;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clk;
  logic          rst;
  logic [NB-1:0] buttons_raw;
  logic [1:0]    channel_select;
  logic [NB-1:0] repeat_en;
  logic [11:0]   pulses4;
  logic [8:0]    pulses3;
  logic [NB-1:0] held4;
  logic [NB-1:0] held3;
  logic          locked4;
  logic          locked3;

  button_router #(
    .NUM_BUTTONS(NB), .NUM_CHANNELS(4), .SEL_W(2), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1'b1)
  ) dut4 (
    .clk(clk), .rst(rst), .buttons_raw(buttons_raw), .channel_select(channel_select),
    .repeat_en(repeat_en), .pulses_out(pulses4), .held(held4), .locked(locked4)
  );

  button_router #(
    .NUM_BUTTONS(NB), .NUM_CHANNELS(3), .SEL_W(2), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1'b1)
  ) dut3 (
    .clk(clk), .rst(rst), .buttons_raw(buttons_raw), .channel_select(channel_select),
    .repeat_en(repeat_en), .pulses_out(pulses3), .held(held3), .locked(locked3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: pressed level as seen through the two-cycle
  // synchroniser delay, run lengths of pressed/released samples, age of the
  // current hold in enabled cycles, debounced level and pending raw pulse.
  bit          pressD1 [NB];
  bit          pressD2 [NB];
  int          run1    [NB];
  int          run0    [NB];
  int          holdAge [NB];
  bit          heldM   [NB];
  bit          pulseM  [NB];
  int          selM;
  bit          lockedM;
  logic [11:0] expP4;
  logic [8:0]  expP3;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int rstStep = 0;

  int count4    [12];
  int first4    [12];
  int last4     [12];
  int count3;
  bit lockedSeen;
  int firstHeld [NB];

  task automatic modelReset();
    for (int b = 0; b < NB; b++) begin
      pressD1[b] = 1'b0; pressD2[b] = 1'b0;
      run1[b] = 0; run0[b] = 0; holdAge[b] = 0;
      heldM[b] = 1'b0; pulseM[b] = 1'b0;
    end
    selM = 0; lockedM = 1'b0; expP4 = '0; expP3 = '0;
  endtask

  // Advance the model across the coming rising edge using the inputs just driven.
  task automatic modelStep();
    int selNew;
    bit anyHeld;
    bit p;
    selNew  = int'(channel_select);
    anyHeld = 1'b0;
    for (int b = 0; b < NB; b++) anyHeld = anyHeld | heldM[b];
    if (selNew != selM && anyHeld) lockedM = 1'b1;
    else if (!anyHeld)             lockedM = 1'b0;
    selM  = selNew;
    expP4 = '0;
    expP3 = '0;
    if (!lockedM) begin
      for (int b = 0; b < NB; b++) begin
        if (pulseM[b]) begin
          if (selNew < 4) expP4[selNew*NB + b] = 1'b1;
          if (selNew < 3) expP3[selNew*NB + b] = 1'b1;
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      p         = pressD2[b];
      pulseM[b] = 1'b0;
      if (!heldM[b]) begin
        if (p) begin
          run1[b]++;
          if (run1[b] >= DB) begin
            heldM[b] = 1'b1; pulseM[b] = 1'b1; holdAge[b] = 0; run0[b] = 0;
          end
        end else begin
          run1[b] = 0;
        end
      end else if (p) begin
        if (run0[b] > 0) begin
          run0[b] = 0; holdAge[b] = 0;
        end else if (repeat_en[b]) begin
          holdAge[b]++;
          if (holdAge[b] == RD || (holdAge[b] > RD && (holdAge[b] - RD) % RP == 0))
            pulseM[b] = 1'b1;
        end
      end else begin
        run0[b]++;
        if (run0[b] >= DB) begin
          heldM[b] = 1'b0; run1[b] = 0; run0[b] = 0;
        end
      end
      pressD2[b] = pressD1[b];
      pressD1[b] = ~buttons_raw[b];
    end
  endtask

  task automatic clearTally();
    for (int i = 0; i < 12; i++) begin
      count4[i] = 0; first4[i] = -1; last4[i] = -1;
    end
    for (int b = 0; b < NB; b++) firstHeld[b] = -1;
    count3 = 0;
    lockedSeen = 1'b0;
  endtask

  function automatic int sumCount4();
    int s;
    s = 0;
    for (int i = 0; i < 12; i++) s += count4[i];
    return s;
  endfunction

  task automatic checkVal(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Compare both instances against the model, then tally observed pulses.
  task automatic checkOutput();
    logic [NB-1:0] hv;
    for (int b = 0; b < NB; b++) hv[b] = heldM[b];
    checks++;
    assert (pulses4 === expP4) else begin
      errors++; $error("FAIL pulses4 @%0d: got %h expected %h", cycle, pulses4, expP4);
    end
    checks++;
    assert (held4 === hv) else begin
      errors++; $error("FAIL held4 @%0d: got %b expected %b", cycle, held4, hv);
    end
    checks++;
    assert (locked4 === lockedM) else begin
      errors++; $error("FAIL locked4 @%0d: got %b expected %b", cycle, locked4, lockedM);
    end
    checks++;
    assert (pulses3 === expP3) else begin
      errors++; $error("FAIL pulses3 @%0d: got %h expected %h", cycle, pulses3, expP3);
    end
    checks++;
    assert (held3 === hv) else begin
      errors++; $error("FAIL held3 @%0d: got %b expected %b", cycle, held3, hv);
    end
    checks++;
    assert (locked3 === lockedM) else begin
      errors++; $error("FAIL locked3 @%0d: got %b expected %b", cycle, locked3, lockedM);
    end
    for (int i = 0; i < 12; i++) begin
      if (pulses4[i] === 1'b1) begin
        count4[i]++;
        if (first4[i] < 0) first4[i] = cycle;
        last4[i] = cycle;
      end
    end
    if (pulses3 !== 9'd0) count3++;
    if (locked4 === 1'b1) lockedSeen = 1'b1;
    for (int b = 0; b < NB; b++)
      if (held4[b] === 1'b1 && firstHeld[b] < 0) firstHeld[b] = cycle;
  endtask

  task automatic applyStimulus(input logic [NB-1:0] pressed, input logic [1:0] sel,
                               input logic [NB-1:0] en);
    @(negedge clk);
    cycle++;
    checkOutput();
    buttons_raw    = ~pressed;
    channel_select = sel;
    repeat_en      = en;
    modelStep();
  endtask

  task automatic holdFor(input int n, input logic [NB-1:0] pressed, input logic [1:0] sel,
                         input logic [NB-1:0] en);
    for (int i = 0; i < n; i++) applyStimulus(pressed, sel, en);
  endtask

  task automatic assertReset();
    rst = 1'b0;
    modelReset();
    #1;
    checkVal("reset_pulses4", int'(pulses4), 0);
    checkVal("reset_held4",   int'(held4),   0);
    checkVal("reset_locked4", int'(locked4), 0);
    checkVal("reset_pulses3", int'(pulses3), 0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    cycle++;
    checkOutput();
    rst     = 1'b1;
    rstStep = cycle;
    modelStep();
  endtask

  initial begin
    int            pressStep;
    logic [NB-1:0] pr;
    logic [NB-1:0] drive;
    logic [NB-1:0] en;
    logic [1:0]    sel;

    rst = 1'b1; buttons_raw = '1; channel_select = '0; repeat_en = '0;
    modelReset();
    clearTally();
    #2;
    assertReset();
    releaseReset();
    holdFor(5, 3'b000, 2'd1, 3'b000);

    $display("[TB] press and release on channel 1");
    clearTally();
    applyStimulus(3'b001, 2'd1, 3'b000);
    pressStep = cycle;
    holdFor(29, 3'b001, 2'd1, 3'b000);
    holdFor(20, 3'b000, 2'd1, 3'b000);
    checkVal("press_count_bit3", count4[3], 1);
    checkVal("press_total", sumCount4(), 1);
    checkVal("press_latency", first4[3] - pressStep, 3 + DB);
    checkVal("held_latency", firstHeld[0] - pressStep, 2 + DB);

    $display("[TB] bounce rejection on button 2");
    clearTally();
    for (int i = 0; i < 20; i++)
      applyStimulus(((i / 2) % 2 == 0) ? 3'b100 : 3'b000, 2'd1, 3'b000);
    holdFor(10, 3'b000, 2'd1, 3'b000);
    checkVal("bounce_total", sumCount4(), 0);
    checkVal("bounce_held", firstHeld[2], -1);

    $display("[TB] auto-repeat on button 1");
    clearTally();
    applyStimulus(3'b010, 2'd0, 3'b010);
    pressStep = cycle;
    holdFor(59, 3'b010, 2'd0, 3'b010);
    holdFor(20, 3'b000, 2'd0, 3'b010);
    checkVal("repeat_count", count4[1], 6);
    checkVal("repeat_first", first4[1] - pressStep, 3 + DB);
    checkVal("repeat_span", last4[1] - first4[1], 52);

    $display("[TB] lock-out across select change");
    holdFor(3, 3'b000, 2'd2, 3'b001);
    clearTally();
    applyStimulus(3'b001, 2'd2, 3'b001);
    holdFor(9, 3'b001, 2'd2, 3'b001);
    checkVal("lock_first_pulse_bit6", count4[6], 1);
    clearTally();
    holdFor(40, 3'b001, 2'd3, 3'b001);
    checkVal("lock_seen", int'(lockedSeen), 1);
    checkVal("lock_suppressed", sumCount4(), 0);
    holdFor(15, 3'b000, 2'd3, 3'b001);
    checkVal("lock_cleared", int'(locked4), 0);
    clearTally();
    applyStimulus(3'b001, 2'd3, 3'b000);
    holdFor(9, 3'b001, 2'd3, 3'b000);
    holdFor(10, 3'b000, 2'd3, 3'b000);
    checkVal("post_lock_bit9", count4[9], 1);
    checkVal("post_lock_total", sumCount4(), 1);

    $display("[TB] out-of-range select on 3-channel instance");
    holdFor(3, 3'b000, 2'd3, 3'b000);
    clearTally();
    applyStimulus(3'b001, 2'd3, 3'b000);
    holdFor(9, 3'b001, 2'd3, 3'b000);
    checkVal("oor_held3", int'(held3[0]), 1);
    holdFor(10, 3'b000, 2'd3, 3'b000);
    checkVal("oor_pulses3", count3, 0);
    checkVal("oor_bit9_dut4", count4[9], 1);

    $display("[TB] async reset during repeat");
    holdFor(3, 3'b000, 2'd1, 3'b100);
    applyStimulus(3'b100, 2'd1, 3'b100);
    holdFor(39, 3'b100, 2'd1, 3'b100);
    checkVal("pre_reset_held", int'(held4[2]), 1);
    @(negedge clk);
    cycle++;
    checkOutput();
    assertReset();
    releaseReset();
    clearTally();
    holdFor(15, 3'b100, 2'd1, 3'b100);
    holdFor(12, 3'b000, 2'd1, 3'b100);
    checkVal("reset_repress_count", count4[5], 1);
    checkVal("reset_repress_latency", first4[5] - rstStep, 3 + DB);

    $display("[TB] randomized traffic");
    pr = '0; en = '0; sel = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 15) == 0) pr[b] = ~pr[b];
      drive = pr;
      if ($urandom_range(0, 19) == 0) drive[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 24) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) en = 3'($urandom);
      applyStimulus(drive, sel, en);
    end
    holdFor(20, 3'b000, sel, en);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_router.md
Name: button_router

Overview:
- Parametrised successor to the fixed 3-button shaper/decoder pair in the BitsPlease top level.
- Synchronises and debounces N raw pushbuttons. Emits one-cycle press pulses, with optional per-button auto-repeat.
- Routes the pulses to one of M consumer channels: process control, access control, game, scoreboard.
- Lock-out rule: a held button never leaks pulses into a newly selected consumer.

Parameters:
- NUM_BUTTONS, 3, number of physical pushbuttons.
- NUM_CHANNELS, 4, number of consumer channels.
- SEL_W, 2, width of channel_select; must be at least clog2(NUM_CHANNELS).
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised samples required to accept a level change.
- REPEAT_DELAY, 25000000, cycles from the first pulse to the first repeat pulse.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses.
- ACTIVE_LOW, 1, 1 means a raw button reads 0 when pressed (DE2 keys).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset; asynchronous, active-low.
- buttons_raw, in, NUM_BUTTONS, unsynchronised pushbutton levels.
- channel_select, in, SEL_W, destination channel for press pulses.
- repeat_en, in, NUM_BUTTONS, per-button auto-repeat enable.
- pulses_out, out, NUM_CHANNELS*NUM_BUTTONS, press pulses. Channel c, button b is at bit c*NUM_BUTTONS+b.
- held, out, NUM_BUTTONS, debounced pressed level.
- locked, out, 1, high while routing is locked out after a select change.

Behaviour:
- Reset (rst=0, async): all sync flops hold the released level; every FSM is in IDLE; counters are 0; pulses_out=0; held=0; locked=0; sel_q=0.
- Synchroniser: two flops per button, then inversion if ACTIVE_LOW. Result p[b]=1 means pressed.
- Per-button FSM with states IDLE, DB_PRESS, PRESSED, REPEAT, DB_RELEASE:
  - IDLE: if p=1, go to DB_PRESS with cnt=1.
  - DB_PRESS: if p=0, go to IDLE. Otherwise cnt++. When cnt==DEBOUNCE_CYCLES, go to PRESSED and raise raw pulse for one cycle.
  - PRESSED: held=1. If p=0, go to DB_RELEASE with cnt=1. Else if repeat_en[b], count to REPEAT_DELAY, then go to REPEAT, raise raw pulse, cnt=0.
  - REPEAT: if p=0, go to DB_RELEASE. Else raise raw pulse every REPEAT_PERIOD cycles.
  - DB_RELEASE: if p=1, return to PRESSED with repeat counter reset. Else cnt++. When cnt==DEBOUNCE_CYCLES, go to IDLE and drop held.
  - Deasserting repeat_en mid-hold stops further repeats immediately and keeps the state.
- Latency: a raw press stable from cycle 0 gives the raw pulse at cycle 2+DEBOUNCE_CYCLES. The registered pulses_out bit is high at cycle 3+DEBOUNCE_CYCLES, exactly 1 cycle wide.
- Routing:
  - channel_select is registered into sel_q every cycle.
  - pulses_out[sel_q*NUM_BUTTONS+b] <= raw pulse[b], provided locked=0 and sel_q<NUM_CHANNELS.
  - All other bits are 0.
  - If sel_q>=NUM_CHANNELS, pulses are dropped silently.
- Lock-out:
  - If sel_q changes while any held bit is 1, set locked=1 in the same cycle as the sel_q update.
  - While locked=1, all pulses are suppressed.
  - locked clears the cycle after all held bits read 0.
  - A select change with no button held never sets locked.
- Simultaneous events:
  - Several buttons may pulse in the same cycle; each routes independently.
  - A pulse in the same cycle as a sel_q change goes to the new sel_q, unless lock is being set.
- Reset mid-press: the FSM returns to IDLE. A still-held button must re-debounce fully and then produces exactly one pulse.
- Counters are wide enough for the largest of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD. They saturate and never wrap.

Decomposition:
- Shared package bits_please_pkg:
  - FSM state encoding: IDLE=0, DB_PRESS=1, PRESSED=2, REPEAT=3, DB_RELEASE=4, 3 bits.
  - clog2 function.
  - Default debounce and repeat constants for the 50 MHz board clock.
- Sub-module button_fsm: one instance per button via generate. Contains the synchroniser, debounce/repeat FSM and counter. Outputs the raw pulse and held.
- The router and lock-out logic live in button_router.

Test Plan:
- Press and release: DEBOUNCE_CYCLES=4, select=1, button 0 pressed at cycle 10 and released at cycle 40 -> pulses_out[3] high only at cycle 17; held high from cycle 16; exactly one pulse.
- Bounce rejection: button 2 toggles every 2 cycles for 20 cycles, then stays released -> no pulse, held stays 0.
- Auto-repeat: REPEAT_DELAY=20, REPEAT_PERIOD=8, repeat_en[1]=1, select=0, button 1 held 60 cycles -> pulses on bit 1 at t0, t0+20, t0+28, t0+36, t0+44, t0+52, and none after release.
- Lock-out: button 0 held with repeat on, select changed 2->3 mid-hold -> locked=1, no pulses on channel 3 bits until release. After release plus debounce, locked=0 and a new press pulses bit 9.
- Out-of-range select: NUM_CHANNELS=3, select=3, press button 0 -> pulses_out all 0, held=1.
- Async reset mid-hold: rst pulled low for 1 cycle while button held in REPEAT -> outputs 0 immediately. With the button still held after reset, exactly one pulse arrives 3+DEBOUNCE_CYCLES cycles after rst deasserts.
